mips_mem_responder: RTL and testbench

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_responder.sv | 148 ++++++++++++++
 tb/tb_mips_mem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder with a three-state request/response FSM and WAIT_CYCLES wait states.
// Optional feature: define MIPS_MEM_BOUNDS_CHECK_EN to fault on req_addr >= DEPTH instead of wrapping.
module mips_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic          oob_q, oob_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [15:0]   txn_q, txn_d;

    logic [31:0]   mem [DEPTH];

    logic accept;
    logic enter_resp;
    logic mem_wr;
    logic in_oob;

`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    assign in_oob = (req_addr >= 32'(DEPTH));
`else
    logic unused_addr;
    assign in_oob      = 1'b0;
    assign unused_addr = ^req_addr[31:AW];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        oob_d      = oob_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        txn_d      = txn_q;
        enter_resp = 1'b0;
        mem_wr     = 1'b0;
        accept     = req_valid && ready_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    oob_d   = in_oob;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The *_d operands are the live request when entering RESP straight from IDLE.
        if (enter_resp) begin
            err_d   = oob_d;
            rdata_d = (we_d || oob_d) ? 32'h0 : mem[addr_d];
            mem_wr  = we_d && !oob_d;
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            oob_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            oob_q   <= oob_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
        end
    end

    // Storage has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[addr_d] <= wdata_d;
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_mips_mem_responder;

    localparam int DEPTH = 1024;
`ifdef MIPS_MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic [15:0] txn_count [2];

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb_q[$];
    logic [31:0] model_mem [int];

    always #5 clk = ~clk;

    mips_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .txn_count(txn_count[0])
    );

    mips_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .txn_count(txn_count[1])
    );

    function automatic logic is_oob(input logic [31:0] a);
        return BC && (a >= 32'(DEPTH));
    endfunction

    // Drives one request until accepted; optionally records the expected response.
    task automatic issue(input int d, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input bit track, output bit ok);
        exp_t e;
        int   key;
        req_we[d] = we;
        req_addr[d] = a;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = req_ready[d];
            @(posedge clk);
            #1;
        end
        req_valid[d] = 1'b0;
        key = d * 65536 + int'(a % DEPTH);
        e.err = is_oob(a);
        if (we) begin
            e.rdata = 32'h0;
            if (!e.err && track) model_mem[key] = wd;
        end else if (e.err) begin
            e.rdata = 32'h0;
        end else begin
            e.rdata = model_mem.exists(key) ? model_mem[key] : 32'hxxxxxxxx;
        end
        if (ok && track) sb_q.push_back(e);
    endtask

    // lat counts edges from the acceptance edge up to the one raising rsp_valid.
    task automatic wait_rsp(input int d, output int lat);
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_xact(input int d, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, output int lat,
                            output logic [31:0] rd, output logic er, output exp_t e);
        bit ok;
        issue(d, we, a, wd, 1'b1, ok);
        lat = -1;
        rd = 32'hxxxxxxxx;
        er = 1'bx;
        e = '1;
        if (ok) begin
            wait_rsp(d, lat);
            rd = rsp_rdata[d];
            er = rsp_err[d];
            if (sb_q.size() > 0) e = sb_q.pop_front();
            if (rsp_ready[d]) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready[0]); end
        n_checks++;
        if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid[0]); end
        n_checks++;
        if (rsp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata[0]); end
        n_checks++;
        if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", rsp_err[0]); end
        n_checks++;
        if (txn_count[0] !== 16'h0) begin n_fail++; $display("FAIL rst_txn: got %h want 0", txn_count[0]); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready: got %b want 0", req_ready[0]); end
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_rst: got %b%b want 11", req_ready[0], req_ready[1]);
        end
    endtask

    task automatic test_store_load();
        int lat;
        logic [31:0] rd;
        logic er;
        exp_t e;
        run_xact(0, 1'b1, 32'd5, 32'hDEADBEEF, lat, rd, er, e);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lat); end
        n_checks++;
        if ({rd, er} !== {e.rdata, e.err}) begin n_fail++; $display("FAIL sw_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        run_xact(0, 1'b0, 32'd5, 32'h0, lat, rd, er, e);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
        n_checks++;
        if (rd !== 32'hDEADBEEF || rd !== e.rdata) begin n_fail++; $display("FAIL lw_data: got %h want %h", rd, e.rdata); end
        n_checks++;
        if (txn_count[0] !== 16'd2) begin n_fail++; $display("FAIL txn_after_2: got %0d want 2", txn_count[0]); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        exp_t e;
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'd5, 32'h0, 1'b1, ok);
        wait_rsp(0, lat);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        n_checks++;
        if (!ok || lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d want 3", lat); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rsp_valid[0], req_ready[0], rsp_rdata[0]} !== {1'b1, 1'b0, e.rdata}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b r=%b d=%h want v=1 r=0 d=%h",
                         i, rsp_valid[0], req_ready[0], rsp_rdata[0], e.rdata);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", rsp_valid[0], req_ready[0]);
        end
        n_checks++;
        if (txn_count[0] !== 16'd3) begin n_fail++; $display("FAIL bp_txn: got %0d want 3", txn_count[0]); end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        req_we[0] = 1'b0;
        req_addr[0] = 32'd5;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req_ready[0]) begin
                if (last >= 0) begin
                    n_checks++;
                    if (i - last !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", i - last); end
                end
                last = i;
            end
            @(posedge clk);
            #1;
        end
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_store();
        bit ok;
        int lat;
        logic [31:0] rd;
        logic er;
        exp_t e;
        run_xact(0, 1'b1, 32'd7, 32'hA5A50007, lat, rd, er, e);
        issue(0, 1'b1, 32'd7, 32'h00001234, 1'b0, ok);
        n_checks++;
        if (!ok || rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got ok=%b v=%b want ok=1 v=0", ok, rsp_valid[0]); end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (txn_count[0] !== 16'h0) begin n_fail++; $display("FAIL mid_rst_txn: got %0d want 0", txn_count[0]); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_xact(0, 1'b0, 32'd7, 32'h0, lat, rd, er, e);
        n_checks++;
        if (rd !== 32'hA5A50007 || rd !== e.rdata) begin n_fail++; $display("FAIL mid_rst_load: got %h want %h", rd, e.rdata); end
        n_checks++;
        if (txn_count[0] !== 16'd1) begin n_fail++; $display("FAIL mid_rst_txn_after: got %0d want 1", txn_count[0]); end
    endtask

    task automatic test_bounds();
        int lat;
        logic [31:0] rd;
        logic er;
        exp_t e;
        run_xact(0, 1'b1, 32'd0, 32'h11110000, lat, rd, er, e);
        run_xact(0, 1'b1, 32'd1024, 32'hBAD0BAD0, lat, rd, er, e);
        n_checks++;
        if ({rd, er} !== {32'h0, BC} || e.err !== BC) begin
            n_fail++;
            $display("FAIL oob_store: got %h/%b want 0/%b", rd, er, BC);
        end
        run_xact(0, 1'b0, 32'd0, 32'h0, lat, rd, er, e);
        n_checks++;
        if (rd !== (BC ? 32'h11110000 : 32'hBAD0BAD0) || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL oob_addr0: got %h want %h", rd, e.rdata);
        end
    endtask

    task automatic test_zero_wait();
        int lat;
        int acc = 0;
        logic [31:0] rd;
        logic er;
        exp_t e;
        run_xact(1, 1'b1, 32'd0, 32'hC0DE0000, lat, rd, er, e);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL w0_sw_latency: got %0d want 1", lat); end
        run_xact(1, 1'b0, 32'd0, 32'h0, lat, rd, er, e);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL w0_lw_latency: got %0d want 1", lat); end
        n_checks++;
        if (rd !== 32'hC0DE0000 || rd !== e.rdata) begin n_fail++; $display("FAIL w0_lw_data: got %h want %h", rd, e.rdata); end
        rsp_ready[1] = 1'b0;
        req_we[1] = 1'b1;
        req_addr[1] = 32'd0;
        req_wdata[1] = 32'h0BAD0BAD;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (req_valid[1] && req_ready[1]) acc++;
            @(posedge clk);
            #1;
        end
        req_valid[1] = 1'b0;
        n_checks++;
        if (acc !== 1) begin n_fail++; $display("FAIL w0_single_accept: got %0d want 1", acc); end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        run_xact(1, 1'b0, 32'd0, 32'h0, lat, rd, er, e);
        n_checks++;
        if (rd !== 32'h0BAD0BAD) begin n_fail++; $display("FAIL w0_held_store: got %h want 0bad0bad", rd); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d] = 1'b0;
            req_addr[d] = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b1;
        end
        test_reset();
        test_store_load();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_store();
        test_bounds();
        test_zero_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
